// File: rtl/counter_pkg.sv
// Shared definitions for the down-counter timer.
// Holds the FSM state encoding and the mode select constants, so the
// timer and any future siblings agree on the same values.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_AUTO    = 1'b1;

endpackage : counter_pkg

// File: rtl/dffe_ar.sv
// Parameterised register with asynchronous active-high reset and load enable.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears q to zero
//   en    - when high, q captures d on the next rising edge
//   d     - next value
//   q     - registered value
module dffe_ar #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : dffe_ar

// File: rtl/down_counter_timer.sv
// Loadable down-counter used as a countdown timer.
// Counts down from a programmed reload value on each tick while running,
// and pulses tc for one cycle at terminal count. Supports one-shot
// (stop in DONE) and auto-reload (restart from reload) modes.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-high; clears all state
//   load     - capture load_val into reload register and counter, go IDLE
//   load_val - reload value; N gives a period of N ticks
//   start    - begin counting (IDLE/DONE), resume from held count (IDLE)
//   stop     - pause counting in RUN, holding the count
//   mode     - 0 = one-shot, 1 = auto-reload; sampled every cycle
//   tick     - decrement strobe, honoured only while running
//   count    - current counter value
//   busy     - high while running
//   tc       - one-cycle terminal-count pulse
//   done     - sticky one-shot completion flag
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state_q, state_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             count_en, reload_en;
  logic [WIDTH-1:0] start_val;

  dffe_ar #(.WIDTH(WIDTH)) u_count_reg (
    .clk   (clk),
    .reset (reset),
    .en    (count_en),
    .d     (count_d),
    .q     (count_q)
  );

  dffe_ar #(.WIDTH(WIDTH)) u_reload_reg (
    .clk   (clk),
    .reset (reset),
    .en    (reload_en),
    .d     (reload_d),
    .q     (reload_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tc_d      = 1'b0;
    count_d   = count_q;
    count_en  = 1'b0;
    reload_d  = reload_q;
    reload_en = 1'b0;
    // Resuming from IDLE keeps a non-zero held count; anything else restarts.
    start_val = (state_q == ST_IDLE && count_q != '0) ? count_q : reload_q;

    if (load) begin
      reload_d  = load_val;
      reload_en = 1'b1;
      count_d   = load_val;
      count_en  = 1'b1;
      state_d   = ST_IDLE;
    end else if (stop) begin
      // stop also masks a same-cycle start, even when not running.
      if (state_q == ST_RUN) begin
        state_d = ST_IDLE;
      end
    end else if (start && state_q != ST_RUN) begin
      count_en = 1'b1;
      if (start_val == '0) begin
        // A zero period completes immediately; auto-reload never free-runs on 0.
        count_d = '0;
        tc_d    = 1'b1;
        state_d = ST_DONE;
      end else begin
        count_d = start_val;
        state_d = ST_RUN;
      end
    end else if (tick && state_q == ST_RUN && count_q != '0) begin
      count_en = 1'b1;
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (mode == MODE_AUTO) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end
    end
  end

  assign count = count_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign tc    = tc_q;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Scoreboard testbench for down_counter_timer: the stimulus process updates a
// behavioural model and queues the expected outputs for each edge; a monitor
// process pops and compares one entry per clock edge.
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .tick     (tick),
    .count    (count),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int busy;
    int tc;
    int done;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model: a count value, the programmed period, and two flags
  // saying whether the timer is running or has finished a one-shot.
  int m_count   = 0;
  int m_reload  = 0;
  bit m_running = 0;
  bit m_fin     = 0;
  bit m_tc      = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_running = 0; m_fin = 0; m_tc = 0;
  endtask

  // Apply one cycle's inputs to the model, following the priority
  // load > stop > start > tick.
  task automatic model_edge(input bit l, input int lv, input bit st, input bit sp,
                            input bit md, input bit tk);
    int first;
    m_tc = 0;
    if (l) begin
      m_reload = lv; m_count = lv; m_running = 0; m_fin = 0;
    end else if (sp) begin
      m_running = 0;
    end else if (st && !m_running) begin
      first = (!m_fin && m_count > 0) ? m_count : m_reload;
      if (first == 0) begin
        m_count = 0; m_tc = 1; m_fin = 1; m_running = 0;
      end else begin
        m_count = first; m_running = 1; m_fin = 0;
      end
    end else if (tk && m_running && m_count > 0) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_tc = 1;
        if (md) m_count = m_reload;
        else begin m_running = 0; m_fin = 1; end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the response
  // expected after the following rising edge.
  task automatic cyc(input bit l, input int lv, input bit st, input bit sp,
                     input bit md, input bit tk);
    exp_t e;
    @(negedge clk);
    load = l; load_val = W'(lv); start = st; stop = sp; mode = md; tick = tk;
    model_edge(l, lv, st, sp, md, tk);
    e.count = m_count; e.busy = m_running; e.tc = m_tc; e.done = m_fin;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    load = 0; start = 0; stop = 0; tick = 0;
  endtask

  // Monitor: one comparison set per rising edge that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'(count), e.count);
        check("busy",  int'(busy),  e.busy);
        check("tc",    int'(tc),    e.tc);
        check("done",  int'(done),  e.done);
      end
    end
  end

  initial begin
    bit r_l, r_st, r_sp, r_tk, r_md;
    int r_lv;

    // Reset state, checked while reset is held.
    #12;
    check("rst_count", int'(count), 0);
    check("rst_busy",  int'(busy),  0);
    check("rst_tc",    int'(tc),    0);
    check("rst_done",  int'(done),  0);
    @(negedge clk);
    reset = 0;
    model_reset();

    // One-shot: 3,2,1,0 with tc at 0, then restart from reload.
    cyc(1, 3, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1);   // tick with accepted start is ignored
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);   // start in DONE reloads 3
    cyc(0, 0, 0, 0, 0, 0);

    // Auto-reload period 2.
    cyc(1, 2, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    repeat (7) cyc(0, 0, 0, 0, 1, 1);

    // Pause / resume.
    cyc(1, 5, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);

    // Zero load in both modes.
    for (int md = 0; md < 2; md++) begin
      cyc(1, 0, 0, 0, md[0], 0);
      cyc(0, 0, 1, 0, md[0], 0);
      cyc(0, 0, 0, 0, md[0], 1);
    end

    // Priority: load beats start and tick while running at count 4.
    cyc(1, 4, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 9, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Async reset mid-run at count 6, checked before the next edge.
    cyc(1, 6, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #3;
    idle_inputs();
    reset = 1;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_busy",  int'(busy),  0);
    check("arst_tc",    int'(tc),    0);
    check("arst_done",  int'(done),  0);
    #1;
    reset = 0;
    model_reset();
    repeat (2) cyc(0, 0, 0, 0, 0, 1);   // ticks do nothing until load/start
    cyc(0, 0, 1, 0, 0, 0);              // start with reload 0 -> immediate done
    cyc(1, 2, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);

    // Randomized traffic; stop and start are never raised together.
    r_md = 0;
    for (int i = 0; i < 600; i++) begin
      r_l  = ($urandom_range(99) < 4);
      r_lv = int'($urandom_range(4));
      r_sp = ($urandom_range(99) < 6);
      r_st = !r_sp && ($urandom_range(99) < 12);
      r_tk = ($urandom_range(99) < 60);
      if ($urandom_range(99) < 5) r_md = ~r_md;
      cyc(r_l, r_lv, r_st, r_sp, r_md, r_tk);
    end

    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_down_counter_timer
